// File: rtl/simon_sequencer.sv
// Simon game controller: grows a colour sequence from the LFSR,
// plays it on the LEDs and checks the player's answer presses.
module simon_sequencer #(
  parameter int MAX_LEN         = 32,
  parameter int PLAY_ON_CYCLES  = 25000000,
  parameter int PLAY_OFF_CYCLES = 12500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] rand_encoding,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic [5:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int T1 = (PLAY_ON_CYCLES > PLAY_OFF_CYCLES) ?
                      PLAY_ON_CYCLES : PLAY_OFF_CYCLES;
  localparam int TMAX = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(PLAY_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(PLAY_OFF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [5:0]    MAX_LV   = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_ON, S_OFF, S_WAIT, S_WIN, S_LOSE
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    level_q, level_d;
  logic [5:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;

  logic [3:0] mem_q [2**AW];
  logic [3:0] sample;
  logic       mem_we;
  logic       onehot;

  assign onehot = (rand_encoding != 4'b0) &&
                  ((rand_encoding & (rand_encoding - 4'd1)) == 4'b0);
  assign sample = onehot ? rand_encoding : 4'b0001;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          level_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        mem_we  = 1'b1;
        level_d = level_q + 6'd1;
        idx_d   = '0;
        tmr_d   = '0;
        state_d = S_ON;
      end
      S_ON: begin
        if (tmr_q == ON_LAST) begin
          tmr_d   = '0;
          state_d = S_OFF;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      S_OFF: begin
        if (tmr_q == OFF_LAST) begin
          tmr_d = '0;
          if (idx_q == level_q - 6'd1) begin
            idx_d   = '0;
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_ON;
          end
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      S_WAIT: begin
        // A press on the timeout cycle still counts as a press.
        if (btn != 4'b0) begin
          if (btn == mem_q[idx_q[AW-1:0]]) begin
            tmr_d = '0;
            if (idx_q < level_q - 6'd1) begin
              idx_d = idx_q + 6'd1;
            end else if (level_q == MAX_LV) begin
              state_d = S_WIN;
            end else begin
              state_d = S_ADD;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = S_LOSE;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The first colour of a round can be the one being written this cycle.
  always_comb begin
    led_d = 4'b0;
    if (state_d == S_ON) begin
      if (state_q == S_ADD && level_q == 6'd0) begin
        led_d = sample;
      end else begin
        led_d = mem_q[idx_d[AW-1:0]];
      end
    end
    busy_d = (state_d == S_ADD) || (state_d == S_ON) ||
             (state_d == S_OFF);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[level_q[AW-1:0]] <= sample;
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game controller for the Simon core. It sits between the `lfsr` random source and the board I/O. Each round it samples the LFSR's one-hot colour encoding into a sequence memory, then plays the whole stored sequence on the four colour LEDs. It then checks the player's button presses against the sequence and advances, wins or loses.

## Interface

Parameters:
- `MAX_LEN`, 32: number of rounds needed to win; sequence memory depth (1..63).
- `PLAY_ON_CYCLES`, 25000000: clock cycles each colour is lit during playback (>=1).
- `PLAY_OFF_CYCLES`, 12500000: dark gap after each lit colour (>=1).
- `TIMEOUT_CYCLES`, 250000000: maximum cycles allowed between player presses (>=1).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; starts a new game from IDLE, WIN or LOSE; ignored in all other states.
- `rand_encoding`  in  4  one-hot colour from `lfsr` (`rand_4_bit_encoding`); free-running.
- `btn`  in  4  player presses; already synchronised and debounced; one-hot, one cycle high per press.
- `led`  out  4  one-hot colour being shown; 0 when dark.
- `level`  out  6  current sequence length (rounds reached).
- `busy`  out  1  high in ADD, PLAY_ON and PLAY_OFF (input not accepted).
- `win`  out  1  high while in WIN.
- `lose`  out  1  high while in LOSE.

## Operation

- State register, `level`, index `idx`, timer `tmr` and memory `mem[0..MAX_LEN-1]` (4 bits each) are all registered.
- Reset (`rst_n`=0, asynchronous, any time, including mid-playback):
  - state goes to IDLE.
  - `level`=0, `idx`=0, `tmr`=0.
  - `led`=0, `busy`=0, `win`=0, `lose`=0.
  - Memory contents are don't-care.
- IDLE:
  - `led`=0.
  - On `start`: `level`←0, go to ADD.
- ADD (exactly 1 cycle):
  - `mem[level]`←`rand_encoding` if it is exactly one-hot, otherwise 4'b0001.
  - `level`←`level`+1, `idx`←0, `tmr`←0, go to PLAY_ON.
- PLAY_ON:
  - `led`=`mem[idx]`, `tmr` increments.
  - When `tmr`=`PLAY_ON_CYCLES`-1: `tmr`←0, go to PLAY_OFF.
- PLAY_OFF:
  - `led`=0.
  - When `tmr`=`PLAY_OFF_CYCLES`-1: `tmr`←0.
    - If `idx`=`level`-1: `idx`←0, go to WAIT_IN.
    - Else `idx`←`idx`+1, go to PLAY_ON.
- WAIT_IN:
  - `led`=0, `tmr` increments every cycle with no press.
  - `btn`≠0 and `btn`=`mem[idx]`: `tmr`←0.
    - If `idx`<`level`-1: `idx`←`idx`+1.
    - Else if `level`=`MAX_LEN`: go to WIN.
    - Else go to ADD.
  - `btn`≠0 and `btn`≠`mem[idx]` (includes multi-hot): go to LOSE.
  - No press and `tmr`=`TIMEOUT_CYCLES`-1: go to LOSE.
- WIN / LOSE:
  - Hold `win`=1 or `lose`=1; `led`=0; `level` is held for display.
  - On `start`: `level`←0, go to ADD.
- `btn` activity outside WAIT_IN is ignored; no queuing.
- `start` outside IDLE/WIN/LOSE is ignored.

## Timing

- All outputs are decoded from registered state; no combinational path from inputs to outputs.
- `start` sampled at edge k:
  - ADD is active in cycle k+1.
  - PLAY_ON (first `led` lit) starts at edge k+2.
- Round of length L takes 1 + L·(`PLAY_ON_CYCLES`+`PLAY_OFF_CYCLES`) cycles from ADD entry to WAIT_IN entry.
- Correct final press at edge p:
  - ADD is active in cycle p+1 (or `win`=1 from edge p+1).
  - `level` is updated at edge p+2.
- Wrong press at edge p: `lose`=1 from edge p+1.
- Timeout: with no press since WAIT_IN entry at edge w (or since the last accepted press at w), `lose`=1 from edge w+`TIMEOUT_CYCLES`.
- A press in the same cycle the timeout threshold is reached takes priority over the timeout.
- `level` never exceeds `MAX_LEN`; `idx` never exceeds `level`-1.

## Test plan

Bench parameters: `MAX_LEN`=3, `PLAY_ON_CYCLES`=4, `PLAY_OFF_CYCLES`=2, `TIMEOUT_CYCLES`=20.

- Reset/idle: hold `rst_n`=0, then release; drive `btn`=4'b0100 with no `start` → `led`=0, `level`=0, `busy`=`win`=`lose`=0 throughout.
- Round 1 playback: `rand_encoding`=4'b0010 at ADD, pulse `start` → `led`=4'b0010 for exactly 4 cycles starting 2 cycles after `start`, then 0 for 2 cycles; `level`=1; `busy`=0 in WAIT_IN.
- Full win: rand values 0010, 1000, 0001 at successive ADDs; answer every round correctly → round 3 replays 0010, 1000, 0001 in order; `win`=1 one cycle after the last press; `level`=3.
- Wrong press: in round 2 press 0010 then 0100 (expected 1000) → `lose`=1 next cycle, `led`=0; a following `start` gives `level`=1 and a new playback.
- Timeout and illegal sample: force `rand_encoding`=4'b0110 at ADD → playback shows 4'b0001. In WAIT_IN send no press → `lose`=1 exactly 20 cycles after WAIT_IN entry. Repeat with a press on cycle 19 → no lose.
- Async reset mid-playback: assert `rst_n`=0 between edges while `led`≠0 → `led`=0 and `busy`=0 immediately, before the next edge; state is IDLE after release.
